// File: rtl/vram_arbiter.sv
// CPU/video arbiter for the shared 1 KiB tile RAM: one RAM access per CPU strobe, inside the tile window.
// Latency: 3 cycles from the first cycle the window is open to WAIT release and valid read data.
// Backpressure: the Z80 is stalled with cpu_waitn low until the access has completed.
module vram_arbiter #(
    parameter int WAIT_LIMIT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_sel,
    input  logic       cpu_rdn,
    input  logic       cpu_wrn,
    input  logic [9:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_waitn,
    input  logic       cmpblk,
    input  logic       vram_busy,
    input  logic [9:0] vid_addr,
    output logic [9:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_ena,
    output logic       ram_wr,
    input  logic [7:0] ram_dout,
    output logic       wait_ovf
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [9:0]    addr_q;
    logic [7:0]    din_q;
    logic          dir_q;      // 1 = write
    logic [7:0]    dout_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ovf_q;

    logic req;
    logic win;

    assign req = cpu_sel & (~cpu_rdn | ~cpu_wrn);
    assign win = cmpblk & ~vram_busy;

    // Saturating increment of the WAIT-cycle counter.
    assign cnt_d = (cnt_q == LIMIT_C) ? cnt_q : cnt_q + 1'b1;

    // Access sequencer: latch the request, wait for the window, issue one access, capture, hold until strobe drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= cpu_addr;
                        din_q   <= cpu_din;
                        // Both strobes low resolves to a write.
                        dir_q   <= ~cpu_wrn;
                        cnt_q   <= '0;
                        state_q <= win ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == LIMIT_C) begin
                        ovf_q <= 1'b1;
                    end
                    if (win) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Committed unconditionally; losing the window now does not cancel the access.
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // RAM read data arrives one cycle after the ACCESS cycle.
                    if (!dir_q) begin
                        dout_q <= ram_dout;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // Park here until the strobe is released so a long strobe only accesses once.
                    if (!req) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM port mux: CPU owns the port only during ACCESS; otherwise video fetches while blanking is low.
    always_comb begin
        ram_addr = vid_addr;
        ram_din  = din_q;
        ram_ena  = ~cmpblk;
        ram_wr   = 1'b0;
        if (state_q == S_ACCESS) begin
            ram_addr = addr_q;
            ram_ena  = 1'b1;
            ram_wr   = dir_q;
        end
    end

    // WAIT is combinational so it falls in the same cycle as the strobe; released while in reset.
    assign cpu_waitn = ~rst_n | ~(req & (state_q != S_DONE));
    assign cpu_dout  = dout_q;
    assign wait_ovf  = ovf_q;

endmodule
